// File: rtl/dvs_pkg.sv
// Shared definitions for the DVS gesture pipeline: grid geometry, cell
// address packing and the time-surface decay function.
package dvs_pkg;

    localparam int GRID_SIZE      = 16;
    localparam int COORD_BITS     = 4;
    localparam int CELL_ADDR_BITS = 8;
    localparam int NUM_CELLS      = GRID_SIZE * GRID_SIZE;

    typedef logic [COORD_BITS-1:0]     coord_t;
    typedef logic [CELL_ADDR_BITS-1:0] cell_addr_t;

    // Cell address is row-major: {y, x}.
    function automatic cell_addr_t cell_addr(input coord_t x, input coord_t y);
        return {y, x};
    endfunction

    // Surface value for a cell of the given age (in ticks). The value starts
    // at full scale and drops by one every 2^decay_shift ticks, flooring at 0.
    // Invalid cells always read 0. Result is returned 32 bits wide; callers
    // truncate to their value width.
    function automatic logic [31:0] decay_value(input logic        cell_valid,
                                                input logic [31:0] age,
                                                input int unsigned decay_shift,
                                                input int unsigned value_bits);
        logic [31:0] steps;
        logic [31:0] vmax;
        steps = age >> decay_shift;
        vmax  = (32'd1 << value_bits) - 32'd1;
        if (!cell_valid || (steps >= vmax)) begin
            return 32'd0;
        end
        return vmax - steps;
    endfunction

endpackage

// File: rtl/ts_stamp_ram.sv
// Simple dual-port stamp RAM: one write port, one registered read port.
// Read-during-write to the same address returns the old contents, which is
// the natural read-first behaviour of a block RAM.
module ts_stamp_ram #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 16
) (
    input  logic                 clk_i,
    input  logic                 wr_en_i,
    input  logic [ADDR_BITS-1:0] wr_addr_i,
    input  logic [DATA_BITS-1:0] wr_data_i,
    input  logic [ADDR_BITS-1:0] rd_addr_i,
    output logic [DATA_BITS-1:0] rd_data_o
);

    logic [DATA_BITS-1:0] mem [2**ADDR_BITS];
    logic [DATA_BITS-1:0] rd_data_q;

    // Write and registered read in one process so the read sees pre-write data.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
        rd_data_q <= mem[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/time_surface_memory.sv
// Per-cell time-surface store for the 16x16 gesture grid. Records the last
// event timestamp per cell, serves decayed surface values on a 1-cycle read
// port, and runs a background scrubber that invalidates stale cells so that
// timestamp wrap-around never brings old activity back to life.
//
// Event handshake: an event transfers on a rising clk edge where both
// evt_valid and evt_ready are high; evt_ready is low during rst and in any
// cycle where clear_all is high, and is otherwise high.
module time_surface_memory
    import dvs_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 12_000_000,
    parameter int TICK_US     = 1000,
    parameter int TS_BITS     = 16,
    parameter int VALUE_BITS  = 8,
    parameter int DECAY_SHIFT = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      evt_valid,
    output logic                      evt_ready,
    input  logic [COORD_BITS-1:0]     evt_x,
    input  logic [COORD_BITS-1:0]     evt_y,
    input  logic                      clear_all,
    input  logic                      ts_read_enable,
    input  logic [CELL_ADDR_BITS-1:0] ts_read_addr,
    output logic [VALUE_BITS-1:0]     ts_read_value,
    output logic [TS_BITS-1:0]        debug_now,
    output logic [15:0]               debug_evt_count
);

    localparam int TICK_CYCLES = (CLK_FREQ_HZ / 1_000_000) * TICK_US;
    localparam int TICK_W      = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

    // Age at which a cell's value has fully decayed to zero.
    localparam longint STALE_TICKS = ((longint'(1) << VALUE_BITS) - 1) << DECAY_SHIFT;
    localparam longint MAX_TS      = (longint'(1) << TS_BITS) - 1;
    localparam logic [TS_BITS-1:0] STALE = TS_BITS'(STALE_TICKS);

    // The scrubber must be able to see a cell as stale before its age wraps.
    if (STALE_TICKS > MAX_TS) begin : g_stale_check
        $error("time_surface_memory: stale age does not fit in TS_BITS");
    end
    if (TICK_CYCLES < 1) begin : g_tick_check
        $error("time_surface_memory: tick period must be at least one cycle");
    end

    // Timebase
    logic [TICK_W-1:0]  tick_cnt_q;
    logic [TS_BITS-1:0] now_q;

    // Event path
    logic       evt_accept;
    cell_addr_t evt_addr;
    logic [15:0] evt_count_q;

    // Valid vector
    logic [NUM_CELLS-1:0] valid_q;
    logic [NUM_CELLS-1:0] valid_d;

    // Shared RAM read port
    cell_addr_t         ram_raddr;
    logic [TS_BITS-1:0] ram_rdata;

    // Scrubber pipeline
    logic               scr_issue;
    cell_addr_t         scr_ptr_q;
    logic               scr_s2_q;
    cell_addr_t         scr_addr_q;
    logic [TS_BITS-1:0] scr_now_q;
    logic               scr_hit_q;
    logic [TS_BITS-1:0] scr_age;
    logic               scr_clear;

    // Downstream read register
    logic               rd_valid_q;
    logic [TS_BITS-1:0] rd_now_q;
    logic               rd_src_q;
    logic [TS_BITS-1:0] rd_hold_q;
    logic [TS_BITS-1:0] rd_stamp;
    logic [TS_BITS-1:0] rd_age;

    assign evt_ready  = ~rst & ~clear_all;
    assign evt_accept = evt_valid & evt_ready;
    assign evt_addr   = cell_addr(evt_x, evt_y);

    // Downstream reads always own the RAM port; the scrubber only uses idle cycles.
    assign scr_issue = ~ts_read_enable;
    assign ram_raddr = ts_read_enable ? ts_read_addr : scr_ptr_q;

    ts_stamp_ram #(
        .ADDR_BITS (CELL_ADDR_BITS),
        .DATA_BITS (TS_BITS)
    ) u_stamp_ram (
        .clk_i     (clk),
        .wr_en_i   (evt_accept),
        .wr_addr_i (evt_addr),
        .wr_data_i (now_q),
        .rd_addr_i (ram_raddr),
        .rd_data_o (ram_rdata)
    );

    // Free-running timestamp: one increment per tick period, wrapping mod 2^TS_BITS.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_q <= '0;
            now_q      <= '0;
        end else if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_q <= '0;
            now_q      <= now_q + TS_BITS'(1);
        end else begin
            tick_cnt_q <= tick_cnt_q + TICK_W'(1);
        end
    end

    // Saturating count of accepted events.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_count_q <= '0;
        end else if (evt_accept && (evt_count_q != 16'hFFFF)) begin
            evt_count_q <= evt_count_q + 16'd1;
        end
    end

    // Scrubber: stage 1 issues a RAM read of the pointer cell and snapshots now;
    // the pointer then advances. A same-edge event on that cell is remembered so
    // the stale check on the pre-write stamp is discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            scr_ptr_q  <= '0;
            scr_s2_q   <= 1'b0;
            scr_addr_q <= '0;
            scr_now_q  <= '0;
            scr_hit_q  <= 1'b0;
        end else begin
            scr_s2_q <= scr_issue;
            if (scr_issue) begin
                scr_addr_q <= scr_ptr_q;
                scr_now_q  <= now_q;
                scr_hit_q  <= evt_accept && (evt_addr == scr_ptr_q);
                scr_ptr_q  <= scr_ptr_q + 8'd1;
            end
        end
    end

    // Stage 2: the RAM output now holds the scrubbed cell's stamp.
    assign scr_age   = scr_now_q - ram_rdata;
    assign scr_clear = scr_s2_q && !scr_hit_q && (scr_age >= STALE);

    // Valid next state: clear_all dominates, then an event set beats a scrub clear.
    always_comb begin
        valid_d = valid_q;
        if (clear_all) begin
            valid_d = '0;
        end else begin
            if (scr_clear) begin
                valid_d[scr_addr_q] = 1'b0;
            end
            if (evt_accept) begin
                valid_d[evt_addr] = 1'b1;
            end
        end
    end

    // Valid vector register.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Read register: snapshot valid and now on an enabled read. The stamp comes
    // straight from the RAM until the scrubber reuses the port, at which point
    // it is parked in rd_hold_q so the served value keeps holding.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_now_q   <= '0;
            rd_src_q   <= 1'b0;
            rd_hold_q  <= '0;
        end else begin
            rd_src_q <= ts_read_enable;
            if (rd_src_q) begin
                rd_hold_q <= ram_rdata;
            end
            if (ts_read_enable) begin
                rd_valid_q <= valid_q[ts_read_addr];
                rd_now_q   <= now_q;
            end
        end
    end

    assign rd_stamp = rd_src_q ? ram_rdata : rd_hold_q;
    assign rd_age   = rd_now_q - rd_stamp;

    assign ts_read_value   = VALUE_BITS'(decay_value(rd_valid_q, 32'(rd_age),
                                                     DECAY_SHIFT, VALUE_BITS));
    assign debug_now       = now_q;
    assign debug_evt_count = evt_count_q;

endmodule

// File: tb/tb_time_surface_memory.sv
// Directed bench for time_surface_memory. One tick per clock cycle and a
// 12-bit timestamp keep decay, staleness and wrap-around within a short run.
module tb_time_surface_memory;

  localparam int TS_BITS    = 12;
  localparam int VALUE_BITS = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  evt_valid;
  logic                  evt_ready;
  logic [3:0]            evt_x;
  logic [3:0]            evt_y;
  logic                  clear_all;
  logic                  ts_read_enable;
  logic [7:0]            ts_read_addr;
  logic [VALUE_BITS-1:0] ts_read_value;
  logic [TS_BITS-1:0]    debug_now;
  logic [15:0]           debug_evt_count;

  int n_cmp  = 0;
  int n_err  = 0;
  int k      = 0;
  int waited = 0;
  logic [TS_BITS-1:0] exp_now = '0;

  time_surface_memory #(
    .CLK_FREQ_HZ (1_000_000),
    .TICK_US     (1),
    .TS_BITS     (TS_BITS),
    .VALUE_BITS  (VALUE_BITS),
    .DECAY_SHIFT (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .evt_valid       (evt_valid),
    .evt_ready       (evt_ready),
    .evt_x           (evt_x),
    .evt_y           (evt_y),
    .clear_all       (clear_all),
    .ts_read_enable  (ts_read_enable),
    .ts_read_addr    (ts_read_addr),
    .ts_read_value   (ts_read_value),
    .debug_now       (debug_now),
    .debug_evt_count (debug_evt_count)
  );

  // clock / reset-aware timestamp model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) exp_now = '0;
    else     exp_now = exp_now + 12'd1;
  end

  // advance one edge; inputs change and outputs are sampled 1 ns after it
  task automatic step();
    @(posedge clk);
    #1;
    k = k + 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; evt_valid = 1'b0; evt_x = '0; evt_y = '0;
    clear_all = 1'b0; ts_read_enable = 1'b0; ts_read_addr = '0;

    // reset state
    repeat (3) step();
    chk("rst_ready", 32'(evt_ready), 32'd0);
    chk("rst_value", 32'(ts_read_value), 32'd0);
    chk("rst_now", 32'(debug_now), 32'd0);
    chk("rst_count", 32'(debug_evt_count), 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_post_rst", 32'(evt_ready), 32'd1);

    // every cell reads 0 after reset
    for (int i = 0; i < 256; i++) begin
      ts_read_enable = 1'b1;
      ts_read_addr   = 8'(i);
      step();
      chk("cold_read", 32'(ts_read_value), 32'd0);
    end
    ts_read_enable = 1'b0;
    chk("now_model_a", 32'(debug_now), 32'(exp_now));

    // event (3,5) then decay by age
    evt_x = 4'd3; evt_y = 4'd5; evt_valid = 1'b1;
    step();
    evt_valid = 1'b0; k = 0;
    ts_read_enable = 1'b1; ts_read_addr = 8'h53;
    step();                                        // age 1
    chk("fresh_255", 32'(ts_read_value), 32'd255);
    chk("count_1", 32'(debug_evt_count), 32'd1);
    ts_read_enable = 1'b0;
    step();
    ts_read_enable = 1'b1;
    step();                                        // age 3
    chk("age3_255", 32'(ts_read_value), 32'd255);
    step();                                        // age 4
    chk("age4_254", 32'(ts_read_value), 32'd254);
    ts_read_enable = 1'b0;
    repeat (3) step();
    ts_read_enable = 1'b1;
    step();                                        // age 8
    chk("age8_253", 32'(ts_read_value), 32'd253);
    ts_read_enable = 1'b0;
    repeat (5) step();
    chk("hold_253", 32'(ts_read_value), 32'd253);

    // continuous reads: decay to 0 and scrubber stalled
    ts_read_enable = 1'b1;
    while (k < 1019) step();
    chk("age1019_1", 32'(ts_read_value), 32'd1);
    step();
    chk("age1020_0", 32'(ts_read_value), 32'd0);
    repeat (1000) step();
    chk("scrub_stalled", 32'(dut.valid_q[8'h53]), 32'd1);

    // release the port: the scrubber clears the stale cell
    ts_read_enable = 1'b0;
    waited = 0;
    while ((dut.valid_q[8'h53] === 1'b1) && (waited < 512)) begin
      step();
      waited++;
    end
    chk("scrub_cleared", 32'(dut.valid_q[8'h53]), 32'd0);

    // no resurrection after the timestamp wraps
    while (k < 4096) step();
    ts_read_enable = 1'b1;
    step();                                        // age mod 4096 = 1
    chk("wrap1_0", 32'(ts_read_value), 32'd0);
    ts_read_enable = 1'b0;
    while (k < 8192) step();
    ts_read_enable = 1'b1;
    step();
    chk("wrap2_0", 32'(ts_read_value), 32'd0);
    ts_read_enable = 1'b0;
    chk("now_model_b", 32'(debug_now), 32'(exp_now));

    // stale-but-valid cell 0x21, then an event lands in its scrub stage-1 cycle
    evt_x = 4'd1; evt_y = 4'd2; evt_valid = 1'b1;
    step();
    evt_valid = 1'b0;
    chk("count_2", 32'(debug_evt_count), 32'd2);
    ts_read_enable = 1'b1; ts_read_addr = 8'h00;
    repeat (1100) step();
    chk("stale_still_valid", 32'(dut.valid_q[8'h21]), 32'd1);
    ts_read_enable = 1'b0;
    waited = 0;
    while ((dut.scr_ptr_q !== 8'h21) && (waited < 300)) begin
      step();
      waited++;
    end
    chk("scrub_ptr_reached", 32'(dut.scr_ptr_q == 8'h21), 32'd1);
    evt_valid = 1'b1;
    step();                                        // stage 1 of cell 0x21
    evt_valid = 1'b0; k = 0;
    ts_read_enable = 1'b1; ts_read_addr = 8'h21;
    step();                                        // stage 2, age 1
    chk("collide_read1", 32'(ts_read_value), 32'd255);
    step();                                        // age 2
    chk("collide_read2", 32'(ts_read_value), 32'd255);
    chk("collide_valid", 32'(dut.valid_q[8'h21]), 32'd1);
    chk("count_3", 32'(debug_evt_count), 32'd3);

    // clear_all with a concurrent event and read
    clear_all = 1'b1; evt_valid = 1'b1; evt_x = 4'd7; evt_y = 4'd7;
    #1;
    chk("clear_not_ready", 32'(evt_ready), 32'd0);
    step();                                        // age 3, pre-clear read
    clear_all = 1'b0; evt_valid = 1'b0;
    chk("clear_preread", 32'(ts_read_value), 32'd255);
    chk("clear_count", 32'(debug_evt_count), 32'd3);
    step();
    chk("cleared_21", 32'(ts_read_value), 32'd0);
    ts_read_addr = 8'h77;
    step();
    chk("cleared_77", 32'(ts_read_value), 32'd0);
    ts_read_addr = 8'h53;
    step();
    chk("cleared_53", 32'(ts_read_value), 32'd0);

    // reset in the middle of scrubbing
    ts_read_enable = 1'b0;
    evt_x = 4'd9; evt_y = 4'd4; evt_valid = 1'b1;
    step();
    evt_valid = 1'b0;
    chk("count_4", 32'(debug_evt_count), 32'd4);
    repeat (10) step();
    rst = 1'b1;
    repeat (2) step();
    chk("midrst_value", 32'(ts_read_value), 32'd0);
    rst = 1'b0;
    ts_read_enable = 1'b1; ts_read_addr = 8'h49;
    step();
    chk("post_rst_read", 32'(ts_read_value), 32'd0);
    chk("post_rst_count", 32'(debug_evt_count), 32'd0);
    chk("post_rst_now", 32'(debug_now), 32'(exp_now));
    ts_read_enable = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
